// File: rtl/lif_neuron_array_if.sv
// Bus between the LIF neuron array and its surroundings: step control,
// per-neuron current feed, spike vector and potential monitor.
interface lif_neuron_array_if #(
  parameter int WIDTH     = 8,
  parameter int N_NEURONS = 4,
  parameter int IDXW      = $clog2(N_NEURONS)
) ();
  logic                 ena;
  logic                 step;
  logic [WIDTH-1:0]     threshold;
  logic [WIDTH-1:0]     cur_in;
  logic [IDXW-1:0]      cur_idx;
  logic                 busy;
  logic [N_NEURONS-1:0] spikes;
  logic                 spikes_valid;
  logic [IDXW-1:0]      mon_sel;
  logic [WIDTH-1:0]     mon_v;

  modport master (
    output ena, step, threshold, cur_in, mon_sel,
    input  cur_idx, busy, spikes, spikes_valid, mon_v
  );

  modport slave (
    input  ena, step, threshold, cur_in, mon_sel,
    output cur_idx, busy, spikes, spikes_valid, mon_v
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed array of leaky integrate-and-fire neurons sharing one
// update datapath, with refractory period, saturation and runtime threshold.
module lif_neuron_array #(
  parameter int WIDTH      = 8,
  parameter int N_NEURONS  = 4,
  parameter int LEAK_SHIFT = 2,
  parameter int REFRAC     = 2,
  parameter int IDXW       = $clog2(N_NEURONS)
) (
  input  logic clk,
  input  logic rst_n,
  lif_neuron_array_if.slave bus
);
  // state  | meaning
  // IDLE   | waiting for step
  // UPDATE | updating neuron cur_idx, one per enabled cycle
  // DONE   | spikes published, spikes_valid pulses
  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  localparam int RW = 4;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_NEURONS - 1);

  state_t               state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]     v_q      [N_NEURONS];
  logic [RW-1:0]        refrac_q [N_NEURONS];
  logic [N_NEURONS-1:0] shadow_q, shadow_d;
  logic [N_NEURONS-1:0] spikes_q;
  logic                 spikes_valid_q;
  logic [WIDTH-1:0]     mon_v_q;

  logic                 start, upd, last;
  logic [WIDTH-1:0]     v_cur, leaked, sat;
  logic [RW-1:0]        r_cur;
  logic [WIDTH:0]       sum;
  logic                 refractory, fire;

  assign start = bus.step && bus.ena && (state_q != S_UPDATE);
  assign upd   = (state_q == S_UPDATE) && bus.ena;
  assign last  = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_UPDATE;
          idx_d   = '0;
        end
      end
      S_UPDATE: begin
        if (bus.ena) begin
          if (last) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (bus.ena) begin
          state_d = start ? S_UPDATE : S_IDLE;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Shared update datapath; the sum is one bit wider so overflow can saturate.
  always_comb begin
    v_cur      = v_q[idx_q];
    r_cur      = refrac_q[idx_q];
    leaked     = v_cur - (v_cur >> LEAK_SHIFT);
    sum        = {1'b0, leaked} + {1'b0, bus.cur_in};
    sat        = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
    refractory = (r_cur != '0);
    fire       = !refractory && (sat >= bus.threshold);
    shadow_d   = shadow_q;
    if (start) shadow_d = '0;
    if (upd) shadow_d[idx_q] = fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      shadow_q       <= '0;
      spikes_q       <= '0;
      spikes_valid_q <= 1'b0;
      mon_v_q        <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i]      <= '0;
        refrac_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      shadow_q       <= shadow_d;
      spikes_valid_q <= upd && last;
      mon_v_q        <= v_q[bus.mon_sel];
      if (upd && last) spikes_q <= shadow_d;
      if (upd) begin
        if (refractory) begin
          v_q[idx_q]      <= '0;
          refrac_q[idx_q] <= r_cur - 1'b1;
        end else if (fire) begin
          v_q[idx_q]      <= '0;
          refrac_q[idx_q] <= RW'(REFRAC);
        end else begin
          v_q[idx_q] <= sat;
        end
      end
    end
  end

  assign bus.cur_idx      = idx_q;
  assign bus.busy         = (state_q == S_UPDATE);
  assign bus.spikes       = spikes_q;
  assign bus.spikes_valid = spikes_valid_q;
  assign bus.mon_v        = mon_v_q;

endmodule
